// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus arbiter: controller states, SPART
// register addresses and the baud-rate divisor table.
`default_nettype none

package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        IDLE   = 3'd2,
        WAIT   = 3'd3,
        XFER   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    function automatic logic [15:0] divisor(input logic [1:0] br_sel);
        logic [15:0] div;
        case (br_sel)
            2'b00:   div = 16'h028A;
            2'b01:   div = 16'h0144;
            2'b10:   div = 16'h00A2;
            default: div = 16'h0050;
        endcase
        return div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
// Two-client round-robin arbiter that programs the SPART baud divisor and then
// serialises single-byte transmit/receive requests onto the SPART register bus.
`default_nettype none

module spart_bus_arbiter
    import spart_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic [1:0]    cfg_q;
    logic          prio_q;
    logic          gnt_q;
    logic          wr_q;
    logic [7:0]    wdata_q;
    logic [CW-1:0] cnt_q;
    logic          iocs_q;
    logic          iorw_q;
    logic [1:0]    ioaddr_q;
    logic [7:0]    dout_q;
    logic          done0_q, done1_q, err0_q, err1_q;
    logic [7:0]    rdata0_q, rdata1_q;

    logic          winner_d;
    logic          ready_d;
    logic [15:0]   div_new_d;
    logic [15:0]   div_cur_d;

    assign winner_d  = (req0 && req1) ? prio_q : req1;
    assign ready_d   = wr_q ? tbr : rda;
    assign div_new_d = divisor(br_cfg);
    assign div_cur_d = divisor(cfg_q);

    // Bus outputs are registered on entry to the state that owns the bus, so
    // they are valid for exactly the cycle spent in CFG_LO/CFG_HI/XFER.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CFG_LO;
            cfg_q    <= 2'b00;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= 8'h00;
            cnt_q    <= '0;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= ADDR_BUF;
            dout_q   <= 8'h00;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= ADDR_BUF;
            case (state_q)
                CFG_LO: begin
                    iocs_q <= 1'b1;
                    iorw_q <= 1'b0;
                    // Straight out of reset the low-byte write has not been issued yet.
                    if (!iocs_q) begin
                        cfg_q    <= br_cfg;
                        ioaddr_q <= ADDR_DIV_LO;
                        dout_q   <= div_new_d[7:0];
                    end else begin
                        ioaddr_q <= ADDR_DIV_HI;
                        dout_q   <= div_cur_d[15:8];
                        state_q  <= CFG_HI;
                    end
                end
                CFG_HI: state_q <= IDLE;
                IDLE: begin
                    if (br_cfg != cfg_q) begin
                        cfg_q    <= br_cfg;
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= ADDR_DIV_LO;
                        dout_q   <= div_new_d[7:0];
                        state_q  <= CFG_LO;
                    end else if (req0 || req1) begin
                        gnt_q   <= winner_d;
                        prio_q  <= ~winner_d;
                        wr_q    <= winner_d ? wr1 : wr0;
                        wdata_q <= winner_d ? wdata1 : wdata0;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (ready_d) begin
                        iocs_q  <= 1'b1;
                        iorw_q  <= ~wr_q;
                        dout_q  <= wdata_q;
                        state_q <= XFER;
                    end else if (cnt_q == CNT_LAST) begin
                        err0_q  <= ~gnt_q;
                        err1_q  <= gnt_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XFER: begin
                    done0_q <= ~gnt_q;
                    done1_q <= gnt_q;
                    if (!wr_q && !gnt_q) rdata0_q <= databus;
                    if (!wr_q &&  gnt_q) rdata1_q <= databus;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= CFG_LO;
            endcase
        end
    end

    assign iocs    = iocs_q;
    assign iorw    = iorw_q;
    assign ioaddr  = ioaddr_q;
    assign databus = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: expected SPART bus cycles are queued
// as stimulus is applied and matched whenever the arbiter asserts iocs.
`default_nettype none

module tb_spart_bus_arbiter;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       req0, req1, wr0, wr1;
    logic [7:0] wdata0, wdata1;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda, tbr;
    logic [7:0] sp_rdata;

    int   checks = 0;
    int   errors = 0;
    int   done0_cnt = 0, done1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
    bus_t sb_q[$];

    always #5 clk = ~clk;

    assign databus = (iocs && iorw) ? sp_rdata : 8'hzz;

    spart_bus_arbiter #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .rda(rda), .tbr(tbr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic rw, input logic [1:0] addr, input logic [7:0] data);
        bus_t e;
        e.rw = rw; e.addr = addr; e.data = data;
        sb_q.push_back(e);
    endtask

    // Every bus cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        bus_t e;
        if (rst === 1'b1 && iocs === 1'b1) begin
            chk("bus_cycle_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("bus_iorw", 32'(iorw), 32'(e.rw));
                chk("bus_addr", 32'(ioaddr), 32'(e.addr));
                chk("bus_data", 32'(databus), 32'(e.data));
            end
        end
        if (done0 === 1'b1) done0_cnt++;
        if (done1 === 1'b1) done1_cnt++;
        if (err0 === 1'b1) err0_cnt++;
        if (err1 === 1'b1) err1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, d1, e1, bad;
        rst = 1'b0; br_cfg = 2'b01;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; wdata0 = 8'h00; wdata1 = 8'h00;
        rda = 0; tbr = 0; sp_rdata = 8'h00;

        // Reset values and the initial divisor programming (9600 -> 0x0144).
        step(2);
        chk("rst_iocs", 32'(iocs), 32'd0);
        chk("rst_iorw", 32'(iorw), 32'd1);
        chk("rst_ioaddr", 32'(ioaddr), 32'd0);
        chk("rst_done", 32'({done0, done1, err0, err1}), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        push(1'b0, 2'b10, 8'h44);
        push(1'b0, 2'b11, 8'h01);
        rst = 1'b1;
        step(3);
        chk("cfg_seq_consumed", 32'(sb_q.size()), 32'd0);
        chk("cfg_then_idle_iocs", 32'(iocs), 32'd0);

        // Client 0 write with tbr high; inputs change after grant are ignored.
        tbr = 1; req0 = 1; wr0 = 1; wdata0 = 8'hA5;
        push(1'b0, 2'b00, 8'hA5);
        d0 = done0_cnt;
        step(1);
        wdata0 = 8'hFF;
        chk("wr_no_early_done", 32'(done0), 32'd0);
        step(1);
        chk("wr_xfer_iocs", 32'(iocs), 32'd1);
        step(1);
        chk("wr_done0_lat3", 32'(done0), 32'd1);
        req0 = 0;
        step(1);
        chk("wr_done0_pulse", 32'(done0), 32'd0);
        chk("wr_done0_count", 32'(done0_cnt), 32'(d0 + 1));

        // Client 1 write that never sees tbr: timeout after 255 WAIT cycles.
        tbr = 0; req1 = 1; wr1 = 1; wdata1 = 8'h5A;
        bad = 0;
        repeat (255) begin
            step(1);
            if (iocs === 1'b1 || err1 === 1'b1 || done1 === 1'b1) bad++;
        end
        chk("to_nothing_early", 32'(bad), 32'd0);
        step(1);
        chk("to_err1", 32'(err1), 32'd1);
        req1 = 0;
        step(1);
        chk("to_err1_pulse", 32'(err1), 32'd0);
        chk("to_no_done1", 32'(done1_cnt), 32'd0);
        chk("to_no_err0", 32'(err0_cnt), 32'd0);

        // Both clients read; the pointer now favours client 0.
        rda = 1; sp_rdata = 8'h3C;
        req0 = 1; wr0 = 0; req1 = 1; wr1 = 0;
        push(1'b1, 2'b00, 8'h3C);
        step(3);
        chk("rd_done0", 32'(done0), 32'd1);
        chk("rd_not_done1", 32'(done1), 32'd0);
        chk("rd_rdata0", 32'(rdata0), 32'h3C);
        req0 = 0; sp_rdata = 8'h7E;
        push(1'b1, 2'b00, 8'h7E);
        step(4);
        chk("rd_done1", 32'(done1), 32'd1);
        chk("rd_rdata1", 32'(rdata1), 32'h7E);
        chk("rd_rdata0_held", 32'(rdata0), 32'h3C);
        req1 = 0; rda = 0;
        step(1);

        // Baud change in IDLE wins over a simultaneous request.
        br_cfg = 2'b11;
        push(1'b0, 2'b10, 8'h50);
        push(1'b0, 2'b11, 8'h00);
        tbr = 1; req0 = 1; wr0 = 1; wdata0 = 8'h11;
        push(1'b0, 2'b00, 8'h11);
        step(1);
        chk("recfg_lo_addr", 32'(ioaddr), 32'h2);
        step(5);
        chk("recfg_then_done0", 32'(done0), 32'd1);
        chk("recfg_all_consumed", 32'(sb_q.size()), 32'd0);
        req0 = 0;
        step(1);

        // Reset while waiting: immediate reset values, no completion, re-config.
        tbr = 0; req1 = 1; wr1 = 1; wdata1 = 8'h77;
        step(3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_iocs", 32'(iocs), 32'd0);
        chk("mid_rst_iorw", 32'(iorw), 32'd1);
        chk("mid_rst_ioaddr", 32'(ioaddr), 32'd0);
        chk("mid_rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        chk("mid_rst_pulses", 32'({done0, done1, err0, err1}), 32'd0);
        d1 = done1_cnt; e1 = err1_cnt;
        req1 = 0; br_cfg = 2'b10;
        step(1);
        push(1'b0, 2'b10, 8'hA2);
        push(1'b0, 2'b11, 8'h00);
        rst = 1'b1;
        step(3);
        chk("post_rst_cfg_consumed", 32'(sb_q.size()), 32'd0);
        chk("post_rst_idle_iocs", 32'(iocs), 32'd0);
        step(2);
        chk("post_rst_no_done1", 32'(done1_cnt), 32'(d1));
        chk("post_rst_no_err1", 32'(err1_cnt), 32'(e1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
